// File: rtl/token_channel_src.sv
// Source side of a token-passing channel: a small slot buffer written in token
// order, read asynchronously by a sink through its one-hot read pointer.
module token_channel_src #(
  parameter int DATA_WIDTH   = 64,
  parameter int BUFFER_WIDTH = 8
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [DATA_WIDTH-1:0]           data_i,
  input  logic                            valid_i,
  output logic                            ready_o,
  output logic [BUFFER_WIDTH-1:0]         writetoken_o,
  input  logic [BUFFER_WIDTH-1:0]         readpointer_i,
  output logic [DATA_WIDTH-1:0]           data_async_o,
  output logic [$clog2(BUFFER_WIDTH):0]   level_o,
  output logic                            err_o
);
  localparam int IW = $clog2(BUFFER_WIDTH);
  localparam int LW = IW + 1;

  function automatic logic [BUFFER_WIDTH-1:0] rotl1(input logic [BUFFER_WIDTH-1:0] v);
    return {v[BUFFER_WIDTH-2:0], v[BUFFER_WIDTH-1]};
  endfunction

  function automatic logic [IW-1:0] idx(input logic [BUFFER_WIDTH-1:0] v);
    logic [IW-1:0] r;
    r = '0;
    for (int i = 0; i < BUFFER_WIDTH; i++)
      if (v[i]) r = r | IW'(i);
    return r;
  endfunction

  function automatic logic onehot(input logic [BUFFER_WIDTH-1:0] v);
    return (v != '0) && ((v & (v - BUFFER_WIDTH'(1))) == '0);
  endfunction

  logic [DATA_WIDTH-1:0]   slot_q [BUFFER_WIDTH];
  logic [BUFFER_WIDTH-1:0] wr_q, prev_rd_q;
  logic                    rst_q, err_q;
  logic                    full, push, rd_oh, viol;
  logic [IW-1:0]           wr_idx, rd_idx;
  logic [LW-1:0]           wr_ext, rd_ext;

  assign full    = (rotl1(wr_q) == readpointer_i);
  assign ready_o = !full;
  assign push    = valid_i && !full && !rst_i;

  assign writetoken_o = wr_q;
  assign err_o        = err_q;

  assign rd_oh  = onehot(readpointer_i);
  assign wr_idx = idx(wr_q);
  assign rd_idx = idx(readpointer_i);
  assign wr_ext = {1'b0, wr_idx};
  assign rd_ext = {1'b0, rd_idx};

  assign data_async_o = rd_oh ? slot_q[rd_idx] : '0;
  assign level_o = (wr_ext >= rd_ext) ? (wr_ext - rd_ext)
                                      : (wr_ext + LW'(BUFFER_WIDTH) - rd_ext);

  // The sink may only hold or step by one slot, and never step past the writer.
  always_comb begin
    viol = 1'b0;
    if (!rd_oh)
      viol = 1'b1;
    else if (readpointer_i != prev_rd_q && readpointer_i != rotl1(prev_rd_q))
      viol = 1'b1;
    else if (readpointer_i == rotl1(prev_rd_q) && prev_rd_q == wr_q)
      viol = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    rst_q <= rst_i;
    if (rst_i) begin
      wr_q      <= BUFFER_WIDTH'(1);
      prev_rd_q <= BUFFER_WIDTH'(1);
      err_q     <= 1'b0;
    end else begin
      prev_rd_q <= readpointer_i;
      if (push) wr_q <= rotl1(wr_q);
      if (!rst_q && viol) err_q <= 1'b1;
    end
  end

  // Slot storage carries no reset; occupancy is defined purely by the tokens.
  for (genvar i = 0; i < BUFFER_WIDTH; i++) begin : g_slot
    always_ff @(posedge clk_i)
      if (push && wr_q[i]) slot_q[i] <= data_i;
  end
endmodule

// File: tb/tb_token_channel_src.sv
// Directed and randomized checks of token_channel_src against a queue-based model.
module tb_token_channel_src;
  localparam int DW = 64;
  localparam int BW = 8;
  localparam int LW = $clog2(BW) + 1;

  logic          clk_i = 1'b0;
  logic          rst_i, valid_i;
  logic [DW-1:0] data_i, data_async_o;
  logic          ready_o, err_o;
  logic [BW-1:0] writetoken_o, readpointer_i;
  logic [LW-1:0] level_o;

  always #5 clk_i = ~clk_i;

  token_channel_src #(.DATA_WIDTH(DW), .BUFFER_WIDTH(BW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .data_i(data_i), .valid_i(valid_i),
    .ready_o(ready_o), .writetoken_o(writetoken_o), .readpointer_i(readpointer_i),
    .data_async_o(data_async_o), .level_o(level_o), .err_o(err_o)
  );

  int            n_vec = 0, n_err = 0;
  logic [DW-1:0] q[$];
  int            m_wr = 0, m_rd = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [BW-1:0] tok;
    tok = '0;
    tok[m_wr] = 1'b1;
    chk("token", 64'(writetoken_o), 64'(tok));
    chk("ready", 64'(ready_o), 64'(q.size() < BW - 1));
    chk("level", 64'(level_o), 64'(q.size()));
    chk("err",   64'(err_o), 64'd0);
    if (q.size() > 0) chk("data", data_async_o, q[0]);
  endtask

  // One clock: optional sink advance, optional push offer, check, then edge.
  task automatic cycle(input bit v, input logic [DW-1:0] d, input bit adv);
    logic [BW-1:0] rp;
    bit acc;
    if (adv) begin
      m_rd = (m_rd + 1) % BW;
      void'(q.pop_front());
    end
    rp = '0;
    rp[m_rd] = 1'b1;
    readpointer_i = rp;
    valid_i = v;
    data_i  = d;
    #1 check_all();
    acc = v && (q.size() < BW - 1);
    @(posedge clk_i);
    if (acc) begin
      q.push_back(d);
      m_wr = (m_wr + 1) % BW;
    end
    @(negedge clk_i);
    valid_i = 1'b0;
  endtask

  // Reset with valid held high to show pushes are suppressed, then one idle cycle.
  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1; valid_i = 1'b1; data_i = 64'hDEAD; readpointer_i = 8'h01;
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0; valid_i = 1'b0;
    q.delete(); m_wr = 0; m_rd = 0;
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  function automatic logic [DW-1:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  initial begin
    logic [DW-1:0] d;
    rst_i = 1'b0; valid_i = 1'b0; data_i = '0; readpointer_i = 8'h01;

    // Reset state
    do_reset();
    #1;
    chk("rst_token", 64'(writetoken_o), 64'h01);
    chk("rst_ready", 64'(ready_o), 64'd1);
    chk("rst_level", 64'(level_o), 64'd0);
    chk("rst_err",   64'(err_o), 64'd0);

    // Single push
    cycle(1'b1, 64'hA5, 1'b0);
    #1;
    chk("single_token", 64'(writetoken_o), 64'h02);
    chk("single_level", 64'(level_o), 64'd1);
    chk("single_data",  data_async_o, 64'hA5);

    // Fill with valid held high
    for (int i = 0; i < 10; i++) cycle(1'b1, rnd64(), 1'b0);
    #1;
    chk("fill_token", 64'(writetoken_o), 64'h80);
    chk("fill_ready", 64'(ready_o), 64'd0);
    chk("fill_level", 64'(level_o), 64'd7);

    // Sink advance and push in the same cycle while full
    d = rnd64();
    cycle(1'b1, d, 1'b1);
    #1;
    chk("sim_token", 64'(writetoken_o), 64'h01);
    chk("sim_level", 64'(level_o), 64'd7);
    chk("sim_tail",  64'(q[$]), d);

    // Randomized traffic with wrap-around
    do_reset();
    for (int i = 0; i < 300; i++)
      cycle(1'($urandom_range(0, 1)), rnd64(), (q.size() > 0) && ($urandom_range(0, 2) != 0));
    while (q.size() > 0) cycle(1'b0, '0, 1'b1);
    #1 check_all();

    // Reset mid-operation at level 4
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, rnd64(), 1'b0);
    #1 chk("mid_level", 64'(level_o), 64'd4);
    do_reset();
    #1;
    chk("mid_token", 64'(writetoken_o), 64'h01);
    chk("mid_level0", 64'(level_o), 64'd0);
    chk("mid_err", 64'(err_o), 64'd0);
    d = rnd64();
    cycle(1'b1, d, 1'b0);
    #1 chk("mid_slot0", data_async_o, d);

    // Sink protocol violations: skip, multi-hot, advance while empty
    for (int k = 0; k < 3; k++) begin
      logic [BW-1:0] bad;
      bad = (k == 0) ? 8'h04 : (k == 1) ? 8'h03 : 8'h02;
      do_reset();
      readpointer_i = bad;
      @(posedge clk_i); @(negedge clk_i);
      #1 chk("viol_set", 64'(err_o), 64'd1);
      readpointer_i = 8'h01;
      for (int j = 0; j < 2; j++) begin @(posedge clk_i); @(negedge clk_i); end
      #1 chk("viol_hold", 64'(err_o), 64'd1);
    end
    do_reset();
    #1 chk("viol_clear", 64'(err_o), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/token_channel_src.md
TOKEN_CHANNEL_SRC -- requirements
Module: token_channel_src

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64: payload width in bits.
REQ-002 SHALL have parameter BUFFER_WIDTH, default 8: number of slots and the token/pointer width; legal values are 2..16.
REQ-003 SHALL have port clk_i, input, 1 bit: single clock; all state is on the rising edge. One clock; reset is synchronous and active-high.
REQ-004 SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port data_i, input, DATA_WIDTH bits: payload from the local producer.
REQ-006 SHALL have port valid_i, input, 1 bit: producer has a payload.
REQ-007 SHALL have port ready_o, output, 1 bit: block accepts the payload this cycle.
REQ-008 SHALL have port writetoken_o, output, BUFFER_WIDTH bits: one-hot marker of the next slot to write, driven to the sink.
REQ-009 SHALL have port readpointer_i, input, BUFFER_WIDTH bits: one-hot marker of the next slot the sink reads, driven by the sink.
REQ-010 SHALL have port data_async_o, output, DATA_WIDTH bits: contents of the slot selected by readpointer_i.
REQ-011 SHALL have port level_o, output, $clog2(BUFFER_WIDTH)+1 bits: number of occupied slots.
REQ-012 SHALL have port err_o, output, 1 bit: sticky flag for a sink protocol violation.

Function
REQ-013 SHALL hold BUFFER_WIDTH slots of DATA_WIDTH bits in a register array; slots are not reset.
REQ-014 SHALL keep the write token wr_q (one-hot) and prev_rd_q, a registered copy of readpointer_i.
REQ-015 SHALL define empty as wr_q == readpointer_i.
REQ-016 SHALL define full as rotl1(wr_q) == readpointer_i, so at most BUFFER_WIDTH-1 slots are usable.
REQ-017 SHALL drive ready_o = !full combinationally and SHALL NOT let ready_o depend on valid_i.
REQ-018 SHALL push on valid_i && ready_o: the slot index(wr_q) is written with data_i, and wr_q becomes rotl1(wr_q) on the next edge.
REQ-019 SHALL keep wr_q and the slots unchanged when there is no push.
REQ-020 SHALL drive writetoken_o = wr_q directly from a register; a push is visible to the sink one cycle after acceptance.
REQ-021 SHALL drive data_async_o = slot[index(readpointer_i)] combinationally, with zero latency from readpointer_i.
REQ-022 SHALL drive data_async_o to all-zeros when readpointer_i is not one-hot.
REQ-023 SHALL compute level_o = (index(wr_q) - index(readpointer_i)) mod BUFFER_WIDTH combinationally; its range is 0..BUFFER_WIDTH-1.
REQ-024 SHALL load prev_rd_q from readpointer_i every cycle.
REQ-025 SHALL set err_o on the next edge when readpointer_i is not one-hot, treating zero and multi-hot values alike.
REQ-026 SHALL set err_o on the next edge when readpointer_i is neither prev_rd_q nor rotl1(prev_rd_q), i.e. a skip or backward step.
REQ-027 SHALL set err_o on the next edge when readpointer_i == rotl1(prev_rd_q) while prev_rd_q == wr_q, i.e. the sink read an empty buffer.
REQ-028 SHALL evaluate the error checks only when rst_i was low in the previous cycle.
REQ-029 SHALL hold err_o set until rst_i is asserted.
REQ-030 SHALL keep accepting pushes while err_o is set; err_o has no effect on the datapath.
REQ-031 SHALL, when a push and a sink advance happen in the same cycle, use the current readpointer_i for the full check, and level_o SHALL reflect both changes on the next cycle.

Reset
REQ-032 SHALL, on rst_i high at a rising edge, set wr_q to 1 (slot 0), prev_rd_q to 1, and err_o to 0.
REQ-033 SHALL suppress pushes during any cycle in which rst_i is high.
REQ-034 SHALL, on reset mid-operation, discard all stored entries logically; the sink is required to return readpointer_i to 1 in the same cycle.
REQ-035 SHALL have these post-reset values with readpointer_i = 1: writetoken_o = 1, ready_o = 1, level_o = 0, err_o = 0.

Verification
REQ-036 Single push: reset, readpointer_i = 1, push 0xA5 -> next cycle writetoken_o = 0x02, level_o = 1, data_async_o = 0xA5.
REQ-037 Fill: BUFFER_WIDTH = 8, valid_i held high, readpointer_i = 1 -> exactly 7 pushes accepted, writetoken_o = 0x80, ready_o = 0, level_o = 7.
REQ-038 Simultaneous event at full: in the full state, readpointer_i steps to 0x02 while valid_i = 1 -> ready_o = 1 that same cycle, push lands in slot 7, writetoken_o wraps to 0x01, level_o = 7.
REQ-039 Wrap-around: 20 pushes interleaved with sink advances, checking the data sequence -> in-order data, no err_o, tokens wrap correctly.
REQ-040 Violations: readpointer_i jumps 0x01 -> 0x04, or is set to 0x03, or advances while empty -> err_o = 1 the next cycle and stays set until rst_i.
REQ-041 Reset mid-operation: with level_o = 4, pulse rst_i with readpointer_i = 1 -> writetoken_o = 0x01, level_o = 0, err_o = 0; the next push lands in slot 0.
